bcd_serial_add_ctrl: RTL and testbench



---
 rtl/bcd_serial_add_ctrl.sv | 140 ++++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder: latches two packed BCD operands on start and adds them
// least-significant digit first through a single 1-digit decimal full adder.

module bcd_fadd_1digit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] raw;

  always_comb begin
    raw = 5'(a_i) + 5'(b_i) + 5'(c_i);
    if (raw >= 5'd10) begin
      s_o = 4'(raw - 5'd10);
      c_o = 1'b1;
    end else begin
      s_o = raw[3:0];
      c_o = 1'b0;
    end
  end
endmodule

module bcd_serial_add_ctrl #(
  parameter int NDIGITS = 4,
  parameter int IDXW    = $clog2(NDIGITS) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   a,
  input  logic [4*NDIGITS-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   sum,
  output logic                   cout,
  output logic                   err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [4*NDIGITS-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic                 carry_q, carry_d, cout_q, cout_d, err_q, err_d;

  logic [3:0] dig_a, dig_b, fa_sum;
  logic       fa_cout, bad_digit;

  always_comb begin
    dig_a     = '0;
    dig_b     = '0;
    bad_digit = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        dig_a = a_q[4*i +: 4];
        dig_b = b_q[4*i +: 4];
      end
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  bcd_fadd_1digit u_fadd (
    .a_i (dig_a),
    .b_i (dig_b),
    .c_i (carry_q),
    .s_o (fa_sum),
    .c_o (fa_cout)
  );

  // NOTE: every output of this block is given a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        carry_d = cin;
        idx_d   = '0;
        sum_d   = '0;
        cout_d  = 1'b0;
        err_d   = bad_digit;
        state_d = bad_digit ? DONE : RUN;
      end
      RUN: begin
        for (int i = 0; i < NDIGITS; i++)
          if (idx_q == IDXW'(i)) sum_d[4*i +: 4] = fa_sum;
        carry_d = fa_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDXW'(NDIGITS-1)) begin
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous and clears the operand registers too; they are
  // few flops, and a clean restart after reset is easier to reason about.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl with NDIGITS=4: hand-computed BCD sums,
// latency, error path, ignored starts, mid-run reset and back-to-back operation.

module tb_bcd_serial_add_ctrl;
  localparam int NDIGITS = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, cin;
  logic [15:0] a, b;
  logic        busy, done, cout, err;
  logic [15:0] sum;

  int checks = 0;
  int errors = 0;

  bcd_serial_add_ctrl #(.NDIGITS(NDIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Launches one operation from IDLE and checks latency, busy, result and the
  // single-cycle done. With poke set, start is re-asserted with other operands
  // in cycles 2 and 3 of the run.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic [15:0] es, input logic ec,
                        input logic ee, input int elat, input bit poke);
    int  n = 0;
    int  busy_low = 0;
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 16'h4321; b = 16'h1111; cin = ~ci;
    n = 1;
    while (!done && n < 20) begin
      if (!busy) busy_low++;
      if (poke && (n == 2 || n == 3)) begin
        start = 1'b1; a = 16'h0101; b = 16'h0202;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, elat);
    check({tag, "_busy_run"}, busy_low, 0);
    check({tag, "_busy_done"}, busy, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_err"}, err, ee);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_sum_held"}, sum, es);
  endtask

  initial begin
    int k, last, cnt, n;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    run_op("add1234", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 5, 1'b0);
    run_op("ripple", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 5, 1'b0);
    run_op("max_cin", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 5, 1'b0);
    run_op("baddigit", 16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1, 1'b0);
    run_op("after_err", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 5, 1'b0);
    run_op("ignore_start", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 5, 1'b1);

    // Reset after two digits have been added.
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("midrun_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_run_busy", busy, 0);
    check("rst_run_done", done, 0);
    check("rst_run_sum", sum, 0);
    check("rst_run_cout", cout, 0);
    check("rst_run_err", err, 0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("rst_no_done", cnt, 0);
    run_op("after_rst", 16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0, 5, 1'b0);

    // Back-to-back: start held high, operand a stepped after each done.
    @(negedge clk);
    k = 1; a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    last = -1; cnt = 0; n = 0;
    for (int c = 0; c < 40 && cnt < 3; c++) begin
      @(negedge clk);
      n = c;
      if (done) begin
        check("b2b_sum", sum, 16'(k + 1));
        if (last >= 0) check("b2b_period", c - last, NDIGITS + 2);
        last = c;
        cnt++;
        k++;
        a = 16'(k);
      end
    end
    start = 1'b0;
    check("b2b_count", cnt, 3);
    if (n >= 39) check("b2b_timeout", n, 0);
    repeat (8) @(negedge clk);
    check("b2b_final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
